// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states,
// opcode encodings and instruction field widths.
package instr_seq_pkg;

    localparam int OP_W  = 4;
    localparam int REG_W = 3;
    localparam int IMM_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_AND  = 4'h3;
    localparam logic [OP_W-1:0] OP_OR   = 4'h4;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h5;
    localparam logic [OP_W-1:0] OP_OUT  = 4'h6;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'h8;
    localparam logic [OP_W-1:0] OP_BNE  = 4'h9;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hA;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

endpackage

// File: rtl/instr_seq_if.sv
// Bus between the sequencer and its ROM / ALU / register-file datapath.
// master = sequencer side, slave = datapath side.
interface instr_seq_if #(
    parameter int PC_W = 8
);
    import instr_seq_pkg::*;

    logic [PC_W-1:0]  pc;
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    logic             zero;
    logic [OP_W-1:0]  alu_op;
    logic             alu_src_imm;
    logic [REG_W-1:0] rf_ra;
    logic [REG_W-1:0] rf_rb;
    logic [REG_W-1:0] rf_wa;
    logic             rf_we;
    logic [IMM_W-1:0] imm_q;
    logic             out_we;
    logic             halted;

    modport master (
        output pc, alu_op, alu_src_imm, rf_ra, rf_rb, rf_wa, rf_we, imm_q, out_we, halted,
        input  op, rs, rt, rd, imm, zero
    );

    modport slave (
        input  pc, alu_op, alu_src_imm, rf_ra, rf_rb, rf_wa, rf_we, imm_q, out_we, halted,
        output op, rs, rt, rd, imm, zero
    );

endinterface

// File: rtl/instr_seq_dec.sv
// Combinational opcode classifier. The *_n outputs are the active-high
// strobe enables the FSM registers in DECODE and fires in WB.
// Undefined opcodes fall through to all-zero, i.e. behave as NOP.
module instr_dec
    import instr_seq_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output logic            rf_we_n_o,
    output logic            alu_src_imm_o,
    output logic            out_we_n_o,
    output logic            is_br_o,
    output logic            is_jmp_o,
    output logic            is_halt_o
);

    // Opcode class lookup, everything defaults to NOP behaviour
    always_comb begin
        rf_we_n_o     = 1'b0;
        alu_src_imm_o = 1'b0;
        out_we_n_o    = 1'b0;
        is_br_o       = 1'b0;
        is_jmp_o      = 1'b0;
        is_halt_o     = 1'b0;
        case (op_i)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: rf_we_n_o = 1'b1;
            OP_ADDI: begin
                rf_we_n_o     = 1'b1;
                alu_src_imm_o = 1'b1;
            end
            OP_OUT:         out_we_n_o = 1'b1;
            OP_BEQ, OP_BNE: is_br_o    = 1'b1;
            OP_JMP:         is_jmp_o   = 1'b1;
            OP_HALT:        is_halt_o  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/WB per instruction,
// driving an asynchronous program ROM and a register-file/ALU datapath.
// Optional feature macro: SINGLE_STEP_EN (adds step_i; WB returns to IDLE
// so each run/step request executes exactly one instruction).
module instr_seq
    import instr_seq_pkg::*;
#(
    parameter int              PC_W      = 8,
    parameter logic [PC_W-1:0] BOOT_ADDR = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
`ifdef SINGLE_STEP_EN
    input  logic step_i,
`endif
    instr_seq_if.master bus
);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [REG_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    logic             wr_q, wr_d, src_q, src_d, ow_q, ow_d;
    logic             br_q, br_d, jmp_q, jmp_d, taken_q, taken_d;

    logic dec_wr, dec_src, dec_ow, dec_br, dec_jmp, dec_halt;
    logic go;

`ifdef SINGLE_STEP_EN
    assign go = run_i | step_i;
    localparam state_e WB_NEXT = S_IDLE;
`else
    assign go = run_i;
    localparam state_e WB_NEXT = S_FETCH;
`endif

    instr_dec u_dec (
        .op_i          (op_q),
        .rf_we_n_o     (dec_wr),
        .alu_src_imm_o (dec_src),
        .out_we_n_o    (dec_ow),
        .is_br_o       (dec_br),
        .is_jmp_o      (dec_jmp),
        .is_halt_o     (dec_halt)
    );

    // State register; reset dominates every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= BOOT_ADDR;
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            wr_q    <= 1'b0;
            src_q   <= 1'b0;
            ow_q    <= 1'b0;
            br_q    <= 1'b0;
            jmp_q   <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            wr_q    <= wr_d;
            src_q   <= src_d;
            ow_q    <= ow_d;
            br_q    <= br_d;
            jmp_q   <= jmp_d;
            taken_q <= taken_d;
        end
    end

    // Next-state: latch ROM fields in FETCH, decode flags in DECODE,
    // resolve the branch in EXEC and update the PC in WB
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        wr_d    = wr_q;
        src_d   = src_q;
        ow_d    = ow_q;
        br_d    = br_q;
        jmp_d   = jmp_q;
        taken_d = taken_q;
        case (state_q)
            S_IDLE: if (go) state_d = S_FETCH;
            S_FETCH: begin
                op_d    = bus.op;
                rs_d    = bus.rs;
                rt_d    = bus.rt;
                rd_d    = bus.rd;
                imm_d   = bus.imm;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                wr_d    = dec_wr;
                src_d   = dec_src;
                ow_d    = dec_ow;
                br_d    = dec_br;
                jmp_d   = dec_jmp;
                state_d = dec_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                // BEQ takes on zero=1, BNE on zero=0
                taken_d = jmp_q | (br_q & (bus.zero ^ (op_q == OP_BNE)));
                state_d = S_WB;
            end
            S_WB: begin
                pc_d    = taken_q ? PC_W'(imm_q) : pc_q + PC_W'(1);
                state_d = WB_NEXT;
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.alu_op      = op_q;
    assign bus.alu_src_imm = src_q;
    assign bus.rf_ra       = rs_q;
    assign bus.rf_rb       = rt_q;
    assign bus.rf_wa       = rd_q;
    assign bus.imm_q       = imm_q;
    assign bus.rf_we       = (state_q == S_WB) & wr_q;
    assign bus.out_we      = (state_q == S_WB) & ow_q;
    assign bus.halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_seq.sv
// Testbench for instr_seq: an instruction-level reference model walks a
// ROM image and queues one expected record per executed instruction; a
// monitor pops records and checks the DUT bus every cycle of each
// instruction.
module tb_instr_seq;

    logic clk = 1'b0;
    logic rst;
    logic run_i;
`ifdef SINGLE_STEP_EN
    logic step_i;
`endif

    instr_seq_if #(.PC_W(8)) bus ();

    instr_seq #(.PC_W(8), .BOOT_ADDR(8'h00)) dut (
        .clk   (clk),
        .rst   (rst),
        .run_i (run_i),
`ifdef SINGLE_STEP_EN
        .step_i(step_i),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // program ROM and zero flag, both looked up by the current pc
    logic [3:0] rom_op  [256];
    logic [2:0] rom_rs  [256];
    logic [2:0] rom_rt  [256];
    logic [2:0] rom_rd  [256];
    logic [7:0] rom_imm [256];
    logic       zt      [256];

    always_comb begin
        bus.op   = rom_op[bus.pc];
        bus.rs   = rom_rs[bus.pc];
        bus.rt   = rom_rt[bus.pc];
        bus.rd   = rom_rd[bus.pc];
        bus.imm  = rom_imm[bus.pc];
        bus.zero = zt[bus.pc];
    end

    typedef struct {
        logic [7:0] pc;
        logic [3:0] op;
        logic [2:0] rs, rt, rd;
        logic [7:0] imm;
        bit         we, ow, src, halt;
    } rec_t;

    rec_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 0;
    int   done_cnt = 0;
    int   halt_cyc = 0;
    bit   have = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_pc", bus.pc, 8'h00);
        chk("rst_halted", bus.halted, 0);
        chk("rst_rf_we", bus.rf_we, 0);
        chk("rst_out_we", bus.out_we, 0);
        chk("rst_alu_op", bus.alu_op, 0);
        chk("rst_imm_q", bus.imm_q, 0);
        chk("rst_rf_addr", {bus.rf_ra, bus.rf_rb, bus.rf_wa}, 0);
        chk("rst_src_imm", bus.alu_src_imm, 0);
    endtask

    task automatic load_nops();
        for (int a = 0; a < 256; a++) begin
            rom_op[a] = 4'h0; rom_rs[a] = 3'h0; rom_rt[a] = 3'h0;
            rom_rd[a] = 3'h0; rom_imm[a] = 8'h00; zt[a] = 1'b0;
        end
    endtask

    task automatic load_random();
        for (int a = 0; a < 256; a++) begin
            rom_op[a]  = 4'($urandom_range(0, 15));
            rom_rs[a]  = 3'($urandom);
            rom_rt[a]  = 3'($urandom);
            rom_rd[a]  = 3'($urandom);
            rom_imm[a] = 8'($urandom);
            zt[a]      = 1'($urandom);
        end
    endtask

    // Model the program at instruction level, then start the DUT and wait
    // for the monitor to consume every record; finishes with a reset taken
    // mid-EXEC (or from HALT) and a reset-state check.
    task automatic run_prog(input int max_ins);
        logic [7:0] p;
        rec_t r;
        int   n;
        bit   halt_exp, taken, ok;
        exp_q.delete();
        p = 8'h00; n = 0; halt_exp = 0;
        while (n < max_ins) begin
            r.pc = p; r.op = rom_op[p]; r.rs = rom_rs[p]; r.rt = rom_rt[p];
            r.rd = rom_rd[p]; r.imm = rom_imm[p];
            r.we   = (r.op >= 4'h1 && r.op <= 4'h5);
            r.ow   = (r.op == 4'h6);
            r.src  = (r.op == 4'h5);
            r.halt = (r.op == 4'hF);
            exp_q.push_back(r);
            n++;
            if (r.halt) begin
                halt_exp = 1;
                break;
            end
            taken = (r.op == 4'hA) || (r.op == 4'h8 && zt[p]) || (r.op == 4'h9 && !zt[p]);
            p = taken ? r.imm : 8'((int'(p) + 1) % 256);
        end
        done_cnt = 0; halt_cyc = 0;
        @(negedge clk); #1;
        rst = 1; run_i = 1;
        @(negedge clk); #1;
        rst = 0; mon_en = 1;
        ok = 0;
        for (int c = 0; c < 4 * n + 60; c++) begin
            @(negedge clk); #1;
            run_i = 1'($urandom);
            if (halt_exp ? (halt_cyc >= 20) : (done_cnt == n)) begin
                ok = 1;
                break;
            end
        end
        chk("run_complete", ok, 1);
        if (!halt_exp && ok) begin
            repeat (3) @(negedge clk);
            chk("pc_mid_exec", bus.pc, p);
            #1;
        end
        rst = 1; mon_en = 0;
        @(negedge clk);
        chk_reset();
    endtask

    // Monitor: phase 0 FETCH, 1 DECODE, 2 EXEC (or HALT hold), 3 WB
    initial begin : monitor
        rec_t cur;
        int   ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                have = 0; ph = 0;
            end else begin
                if (!have && exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    have = 1; ph = 0;
                end
                if (have) begin
                    if (ph < 3) begin
                        chk("strobe_rf_we", bus.rf_we, 0);
                        chk("strobe_out_we", bus.out_we, 0);
                    end
                    case (ph)
                        0: begin
                            chk("fetch_pc", bus.pc, cur.pc);
                            chk("fetch_halted", bus.halted, 0);
                        end
                        2: begin
                            chk("halted", bus.halted, cur.halt);
                            if (cur.halt) begin
                                chk("halt_pc", bus.pc, cur.pc);
                                halt_cyc++;
                            end
                        end
                        3: begin
                            chk("wb_rf_we", bus.rf_we, cur.we);
                            chk("wb_out_we", bus.out_we, cur.ow);
                            chk("wb_alu_op", bus.alu_op, cur.op);
                            chk("wb_src_imm", bus.alu_src_imm, cur.src);
                            chk("wb_imm_q", bus.imm_q, cur.imm);
                            chk("wb_rf_addr", {bus.rf_ra, bus.rf_rb, bus.rf_wa},
                                {cur.rs, cur.rt, cur.rd});
                            done_cnt++;
                        end
                        default: ;
                    endcase
                    if (!(cur.halt && ph == 2)) ph++;
                    if (ph == 4) begin
                        have = 0; ph = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst = 1; run_i = 0;
`ifdef SINGLE_STEP_EN
        step_i = 0;
`endif
        load_nops();
        repeat (2) @(negedge clk);
        chk_reset();
`ifdef SINGLE_STEP_EN
        #1 rst = 0;
        repeat (5) @(negedge clk);
        chk("step_idle_pc", bus.pc, 8'h00);
        for (int s = 1; s <= 2; s++) begin
            #1 step_i = 1;
            @(negedge clk); #1 step_i = 0;
            repeat (10) @(negedge clk);
            chk("step_pc", bus.pc, 8'(s));
        end
`else
        // ADDI r1, 0x0F then HALT
        load_nops();
        rom_op[0] = 4'h5; rom_rd[0] = 3'd1; rom_imm[0] = 8'h0F; rom_op[1] = 4'hF;
        run_prog(10);
        // BEQ/BNE at 0x03 to 0x0A, both zero values
        for (int b = 0; b < 4; b++) begin
            load_nops();
            rom_op[3] = (b < 2) ? 4'h8 : 4'h9; rom_imm[3] = 8'h0A;
            zt[3] = 1'(b % 2);
            rom_op[8'h0A] = 4'hF; rom_op[8'h04] = 4'hF;
            run_prog(20);
        end
        // JMP at 0xFF to 0x02
        load_nops();
        rom_op[0] = 4'hA; rom_imm[0] = 8'hFF;
        rom_op[8'hFF] = 4'hA; rom_imm[8'hFF] = 8'h02; rom_op[2] = 4'hF;
        run_prog(20);
        // NOP at 0xFF wraps to 0x00
        load_nops();
        rom_op[0] = 4'hA; rom_imm[0] = 8'hFE;
        run_prog(4);
        // HALT at 0x0B, run toggles while halted
        load_nops();
        rom_op[8'h0B] = 4'hF;
        run_prog(100);
        // reset taken mid-EXEC at pc 0x05
        load_nops();
        run_prog(5);
        // random programs
        for (int k = 0; k < 8; k++) begin
            load_random();
            run_prog(40);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
